// File: rtl/theta_tracker_if.sv
// rtl/theta_tracker_if.sv - sensor input and angle outputs of the theta tracker
interface theta_tracker_if #(
    parameter int THETA_WIDTH  = 10,
    parameter int PERIOD_WIDTH = 32,
    parameter int REV_WIDTH    = 16
);
    logic                    ir_tripped;
    logic [THETA_WIDTH-1:0]  theta;
    logic                    theta_valid;
    logic                    theta_step;
    logic [PERIOD_WIDTH-1:0] period_out;
    logic [REV_WIDTH-1:0]    rev_count;

    modport master (
        input  ir_tripped,
        output theta, theta_valid, theta_step, period_out, rev_count
    );

    modport slave (
        output ir_tripped,
        input  theta, theta_valid, theta_step, period_out, rev_count
    );
endinterface

// File: rtl/theta_tracker.sv
// rtl/theta_tracker.sv - IR index pulses to uniform theta index via DDA; PERIOD_AVG_EN averages the period in TRACK
module theta_tracker #(
    parameter int ROTATIONAL_RES = 1024,
    parameter int PERIOD_WIDTH   = 32,
    parameter int MIN_PERIOD     = 4096,
    parameter int STALL_CYCLES   = 2**24,
    parameter int SYNC_STAGES    = 2,
    parameter int REV_WIDTH      = 16
) (
    input  logic            clk_in,
    input  logic            rst_in,
    theta_tracker_if.master bus
);
    localparam int THETA_WIDTH = $clog2(ROTATIONAL_RES);
    localparam logic [PERIOD_WIDTH-1:0] MIN_P     = PERIOD_WIDTH'(MIN_PERIOD);
    localparam logic [PERIOD_WIDTH-1:0] STALL_P   = PERIOD_WIDTH'(STALL_CYCLES);
    localparam logic [PERIOD_WIDTH:0]   RES_EXT   = (PERIOD_WIDTH+1)'(ROTATIONAL_RES);
    localparam logic [THETA_WIDTH-1:0]  THETA_MAX = THETA_WIDTH'(ROTATIONAL_RES - 1);

    typedef enum logic [1:0] {IDLE, ACQUIRE, TRACK} state_t;

    state_t                  state_q, state_d;
    logic [SYNC_STAGES-1:0]  sync_q;
    logic                    sync_prev_q;
    logic [PERIOD_WIDTH-1:0] cnt_q, cnt_d;
    logic [PERIOD_WIDTH-1:0] acc_q, acc_d;
    logic [PERIOD_WIDTH-1:0] period_q, period_d;
    logic [THETA_WIDTH-1:0]  theta_q, theta_d;
    logic [REV_WIDTH-1:0]    rev_q, rev_d;
    logic                    theta_step_q;

    logic                    rise;
    logic                    accepted;
    logic                    stall;
    logic [PERIOD_WIDTH:0]   acc_sum;
`ifdef PERIOD_AVG_EN
    logic [PERIOD_WIDTH:0]   period_sum;
    assign period_sum = {1'b0, period_q} + {1'b0, cnt_q};
`endif

    // Rise is judged against the last synchronised level, not the raw pin.
    assign rise     = sync_q[SYNC_STAGES-1] & ~sync_prev_q;
    // In IDLE there is no interval yet, so any rise starts acquisition.
    assign accepted = rise & ((state_q == IDLE) | (cnt_q >= MIN_P));
    assign stall    = (state_q != IDLE) & (cnt_q == STALL_P);
    // One extra bit keeps acc + RES from wrapping before the compare.
    assign acc_sum  = {1'b0, acc_q} + RES_EXT;

    // Metastability chain and edge-detect history for the sensor pin.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            sync_q      <= '0;
            sync_prev_q <= 1'b0;
        end else begin
            sync_q      <= {sync_q[SYNC_STAGES-2:0], bus.ir_tripped};
            sync_prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    // Next state: stall beats an accepted edge, which beats a DDA step.
    always_comb begin
        state_d  = state_q;
        cnt_d    = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
        acc_d    = acc_q;
        period_d = period_q;
        theta_d  = theta_q;
        rev_d    = rev_q;
        case (state_q)
            IDLE: begin
                theta_d = '0;
                if (accepted) begin
                    state_d = ACQUIRE;
                    cnt_d   = PERIOD_WIDTH'(1);
                end
            end
            ACQUIRE: begin
                if (stall) begin
                    state_d = IDLE;
                end else if (accepted) begin
                    state_d  = TRACK;
                    cnt_d    = PERIOD_WIDTH'(1);
                    period_d = cnt_q;
                    theta_d  = '0;
                    acc_d    = '0;
                end
            end
            TRACK: begin
                if (stall) begin
                    state_d = IDLE;
                    theta_d = '0;
                end else if (accepted) begin
                    cnt_d    = PERIOD_WIDTH'(1);
`ifdef PERIOD_AVG_EN
                    period_d = PERIOD_WIDTH'(period_sum >> 1);
`else
                    period_d = cnt_q;
`endif
                    theta_d  = '0;
                    acc_d    = '0;
                    rev_d    = rev_q + 1'b1;
                end else if (acc_sum >= {1'b0, period_q}) begin
                    acc_d = PERIOD_WIDTH'(acc_sum - {1'b0, period_q});
                    // A slower revolution parks theta at the last index until resync.
                    if (theta_q != THETA_MAX) begin
                        theta_d = theta_q + 1'b1;
                    end
                end else begin
                    acc_d = PERIOD_WIDTH'(acc_sum);
                end
            end
            default: begin
                state_d = IDLE;
                theta_d = '0;
            end
        endcase
    end

    // Tracker state registers; the step strobe lands with the new theta value.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            acc_q        <= '0;
            period_q     <= '0;
            theta_q      <= '0;
            rev_q        <= '0;
            theta_step_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            acc_q        <= acc_d;
            period_q     <= period_d;
            theta_q      <= theta_d;
            rev_q        <= rev_d;
            theta_step_q <= (theta_d != theta_q);
        end
    end

    assign bus.theta       = theta_q;
    assign bus.theta_valid = (state_q == TRACK);
    assign bus.theta_step  = theta_step_q;
    assign bus.period_out  = period_q;
    assign bus.rev_count   = rev_q;
endmodule
